// File: rtl/decode_if.sv
// Bus between the controller/fetch side and the decode stage.
// The instr_count signal exists only when DECODE_INSTR_COUNT_EN is defined.
interface decode_if;
    logic        enable_decode;
    logic [15:0] dout;
    logic [15:0] npc_in;
    logic [15:0] IR;
    logic [15:0] npc_out;
    logic [5:0]  E_control;
    logic [1:0]  W_control;
    logic        Mem_control;
    logic        decode_valid;
    logic        illegal_op;
`ifdef DECODE_INSTR_COUNT_EN
    logic [15:0] instr_count;

    modport master (
        output enable_decode, dout, npc_in,
        input  IR, npc_out, E_control, W_control, Mem_control,
               decode_valid, illegal_op, instr_count
    );
    modport slave (
        input  enable_decode, dout, npc_in,
        output IR, npc_out, E_control, W_control, Mem_control,
               decode_valid, illegal_op, instr_count
    );
`else
    modport master (
        output enable_decode, dout, npc_in,
        input  IR, npc_out, E_control, W_control, Mem_control,
               decode_valid, illegal_op
    );
    modport slave (
        input  enable_decode, dout, npc_in,
        output IR, npc_out, E_control, W_control, Mem_control,
               decode_valid, illegal_op
    );
`endif
endinterface

// File: rtl/decode.sv
// LC-3 style decode stage: captures the fetched word and produces execute/memory/writeback controls.
// Optional DECODE_INSTR_COUNT_EN adds a wrapping 16-bit count of enabled decodes.
module decode (
    input  logic   clock,
    input  logic   reset,
    decode_if.slave bus
);
    logic [3:0]  opcode;
    logic [1:0]  alu_control;
    logic [1:0]  pcselect1;
    logic        pcselect2;
    logic        op2select;
    logic [1:0]  w_next;
    logic        mem_next;
    logic        illegal_next;

    logic [15:0] ir_q;
    logic [15:0] npc_q;
    logic [5:0]  e_q;
    logic [1:0]  w_q;
    logic        mem_q;
    logic        valid_q;
    logic        illegal_q;

    assign opcode = bus.dout[15:12];

    always_comb begin
        alu_control  = 2'b00;
        pcselect1    = 2'b00;
        pcselect2    = 1'b0;
        op2select    = 1'b0;
        w_next       = 2'd0;
        mem_next     = 1'b0;
        illegal_next = 1'b0;
        case (opcode)
            4'b0001: op2select = ~bus.dout[5];                                  // ADD
            4'b0101: begin alu_control = 2'b01; op2select = ~bus.dout[5]; end  // AND
            4'b1001: begin alu_control = 2'b10; op2select = 1'b1; end          // NOT
            4'b0000, 4'b0011: begin pcselect1 = 2'b01; pcselect2 = 1'b1; end   // BR, ST
            4'b0010: begin pcselect1 = 2'b01; pcselect2 = 1'b1; w_next = 2'd1; end // LD
            4'b1010: begin
                pcselect1 = 2'b01; pcselect2 = 1'b1; w_next = 2'd1; mem_next = 1'b1; // LDI
            end
            4'b1011: begin pcselect1 = 2'b01; pcselect2 = 1'b1; mem_next = 1'b1; end // STI
            4'b1110: begin pcselect1 = 2'b01; pcselect2 = 1'b1; w_next = 2'd2; end   // LEA
            4'b0110: begin pcselect1 = 2'b10; w_next = 2'd1; end                     // LDR
            4'b0111: pcselect1 = 2'b10;                                              // STR
            4'b1100: pcselect1 = 2'b11;                                              // JMP
            default: illegal_next = 1'b1;  // 0100, 1000, 1101, 1111: controls stay 0
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            ir_q      <= 16'h0000;
            npc_q     <= 16'h0000;
            e_q       <= 6'b000000;
            w_q       <= 2'd0;
            mem_q     <= 1'b0;
            valid_q   <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            valid_q <= bus.enable_decode;
            if (bus.enable_decode) begin
                ir_q      <= bus.dout;
                npc_q     <= bus.npc_in;
                e_q       <= {alu_control, pcselect1, pcselect2, op2select};
                w_q       <= w_next;
                mem_q     <= mem_next;
                illegal_q <= illegal_next;
            end
        end
    end

    assign bus.IR           = ir_q;
    assign bus.npc_out      = npc_q;
    assign bus.E_control    = e_q;
    assign bus.W_control    = w_q;
    assign bus.Mem_control  = mem_q;
    assign bus.decode_valid = valid_q;
    assign bus.illegal_op   = illegal_q;

`ifdef DECODE_INSTR_COUNT_EN
    logic [15:0] count_q;

    always_ff @(posedge clock) begin
        if (!reset)
            count_q <= 16'h0000;
        else if (bus.enable_decode)
            count_q <= count_q + 16'h0001;
    end

    assign bus.instr_count = count_q;
`endif
endmodule

// File: tb/tb_decode.sv
// Bench for decode: directed vector table, randomized run against a behavioural model,
// and (with DECODE_INSTR_COUNT_EN) the counter wrap/reset sequence.
module tb_decode;
    logic clock;
    logic reset;

    decode_if bus ();

    decode dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    // ---------------- clock / reset ----------------
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // ---------------- bookkeeping ----------------
    int n_cmp  = 0;
    int n_fail = 0;

    // Packed observation: {IR, npc_out, E_control, W_control, Mem_control, decode_valid, illegal_op}
    logic [42:0] exp_q[$];

    // Behavioural model state
    logic [15:0] m_ir, m_npc, m_cnt;
    logic [5:0]  m_e;
    logic [1:0]  m_w;
    logic        m_m, m_valid, m_ill;

    typedef struct {
        logic        rst_n;
        logic        en;
        logic [15:0] din;
        logic [15:0] npc;
        logic [15:0] ir;
        logic [15:0] npc_o;
        logic [5:0]  e;
        logic [1:0]  w;
        logic        m;
        logic        valid;
        logic        ill;
    } vec_t;

    vec_t vecs[16];

    function automatic logic [42:0] observe();
        return {bus.IR, bus.npc_out, bus.E_control, bus.W_control,
                bus.Mem_control, bus.decode_valid, bus.illegal_op};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
        n_cmp++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp_v);
        end
    endtask

    // Controls derived from the instruction-set tables, field by field.
    task automatic ref_controls(input logic [15:0] d, output logic [5:0] e,
                                output logic [1:0] w, output logic m, output logic ill);
        int op;
        logic [1:0] alu, pc1;
        logic pc2, op2;
        op  = int'(d[15:12]);
        ill = op inside {4, 8, 13, 15};
        alu = (op == 5) ? 2'd1 : (op == 9) ? 2'd2 : 2'd0;
        op2 = (op == 1 || op == 5) ? ~d[5] : (op == 9);
        pc2 = op inside {0, 2, 3, 10, 11, 14};
        pc1 = pc2 ? 2'd1 : (op inside {6, 7}) ? 2'd2 : (op == 12) ? 2'd3 : 2'd0;
        w   = (op inside {2, 6, 10}) ? 2'd1 : (op == 14) ? 2'd2 : 2'd0;
        m   = op inside {10, 11};
        e   = {alu, pc1, pc2, op2};
    endtask

    task automatic model_step(input logic rst_n, input logic en, input logic [15:0] d,
                              input logic [15:0] npc);
        logic [5:0] e;
        logic [1:0] w;
        logic m, ill;
        if (!rst_n) begin
            m_ir = '0; m_npc = '0; m_e = '0; m_w = '0; m_m = 0; m_valid = 0; m_ill = 0; m_cnt = '0;
        end else begin
            m_valid = en;
            if (en) begin
                ref_controls(d, e, w, m, ill);
                m_ir = d; m_npc = npc; m_e = e; m_w = w; m_m = m; m_ill = ill;
                m_cnt = m_cnt + 16'd1;
            end
        end
        exp_q.push_back({m_ir, m_npc, m_e, m_w, m_m, m_valid, m_ill});
    endtask

    // ---------------- driver ----------------
    // Called at a falling edge: drive, clock once, return at the next falling edge.
    task automatic drive(input logic rst_n, input logic en, input logic [15:0] d,
                         input logic [15:0] npc);
        reset             = rst_n;
        bus.enable_decode = en;
        bus.dout          = d;
        bus.npc_in        = npc;
        model_step(rst_n, en, d, npc);
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic scoreboard_check(input string name);
        logic [42:0] exp_v;
        if (exp_q.size() == 0) begin
            n_cmp++; n_fail++;
            $display("FAIL %s: scoreboard queue empty", name);
        end else begin
            exp_v = exp_q.pop_front();
            check(name, 64'(observe()), 64'(exp_v));
`ifdef DECODE_INSTR_COUNT_EN
            check({name, "_count"}, 64'(bus.instr_count), 64'(m_cnt));
`endif
        end
    endtask

    initial begin
        vecs[0]  = '{0, 1, 16'h1042, 16'h3001, 16'h0000, 16'h0000, 6'h00, 2'd0, 0, 0, 0};
        vecs[1]  = '{0, 1, 16'h1042, 16'h3001, 16'h0000, 16'h0000, 6'h00, 2'd0, 0, 0, 0};
        vecs[2]  = '{1, 1, 16'h1042, 16'h3001, 16'h1042, 16'h3001, 6'h01, 2'd0, 0, 1, 0};
        vecs[3]  = '{1, 1, 16'hA005, 16'h3002, 16'hA005, 16'h3002, 6'h06, 2'd1, 1, 1, 0};
        vecs[4]  = '{1, 0, 16'h5020, 16'h3003, 16'hA005, 16'h3002, 6'h06, 2'd1, 1, 0, 0};
        vecs[5]  = '{1, 1, 16'hC1C0, 16'h3004, 16'hC1C0, 16'h3004, 6'h0C, 2'd0, 0, 1, 0};
        vecs[6]  = '{1, 1, 16'hF025, 16'h3005, 16'hF025, 16'h3005, 6'h00, 2'd0, 0, 1, 1};
        vecs[7]  = '{1, 1, 16'h6042, 16'h3006, 16'h6042, 16'h3006, 6'h08, 2'd1, 0, 1, 0};
        vecs[8]  = '{1, 1, 16'hE0FF, 16'h3007, 16'hE0FF, 16'h3007, 6'h06, 2'd2, 0, 1, 0};
        vecs[9]  = '{1, 1, 16'h5020, 16'h3008, 16'h5020, 16'h3008, 6'h10, 2'd0, 0, 1, 0};
        vecs[10] = '{1, 1, 16'h9FFF, 16'h3009, 16'h9FFF, 16'h3009, 6'h21, 2'd0, 0, 1, 0};
        vecs[11] = '{1, 1, 16'hB000, 16'h300A, 16'hB000, 16'h300A, 6'h06, 2'd0, 1, 1, 0};
        vecs[12] = '{0, 1, 16'h1042, 16'h300B, 16'h0000, 16'h0000, 6'h00, 2'd0, 0, 0, 0};
        vecs[13] = '{1, 1, 16'h0000, 16'h0001, 16'h0000, 16'h0001, 6'h06, 2'd0, 0, 1, 0};
        vecs[14] = '{1, 1, 16'h7000, 16'h0002, 16'h7000, 16'h0002, 6'h08, 2'd0, 0, 1, 0};
        vecs[15] = '{1, 1, 16'h5000, 16'h0003, 16'h5000, 16'h0003, 6'h11, 2'd0, 0, 1, 0};

        reset = 0; bus.enable_decode = 0; bus.dout = '0; bus.npc_in = '0;
        m_ir = '0; m_npc = '0; m_e = '0; m_w = '0; m_m = 0; m_valid = 0; m_ill = 0; m_cnt = '0;
        @(negedge clock);

        // Directed table
        for (int i = 0; i < 16; i++) begin
            drive(vecs[i].rst_n, vecs[i].en, vecs[i].din, vecs[i].npc);
            check($sformatf("vec%0d", i), 64'(observe()),
                  64'({vecs[i].ir, vecs[i].npc_o, vecs[i].e, vecs[i].w,
                       vecs[i].m, vecs[i].valid, vecs[i].ill}));
            scoreboard_check($sformatf("vec%0d_model", i));
        end

        // Illegal flag persists across a held cycle, then clears on a legal decode
        drive(1, 1, 16'h4ABC, 16'h0100);
        scoreboard_check("illegal_0100");
        drive(1, 0, 16'h1234, 16'h0101);
        check("illegal_hold", 64'(bus.illegal_op), 64'd1);
        scoreboard_check("illegal_hold_model");
        drive(1, 1, 16'h8000, 16'h0102);
        scoreboard_check("illegal_1000");
        drive(1, 1, 16'hD000, 16'h0103);
        scoreboard_check("illegal_1101");
        drive(1, 1, 16'h2000, 16'h0104);
        check("illegal_clear", 64'(bus.illegal_op), 64'd0);
        scoreboard_check("ld_after_illegal");

        // Randomized stream with occasional resets
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 29) != 0), ($urandom_range(0, 3) != 0),
                  16'($urandom), 16'($urandom));
            scoreboard_check($sformatf("rand%0d", i));
        end

`ifdef DECODE_INSTR_COUNT_EN
        drive(0, 0, 16'h0000, 16'h0000);
        scoreboard_check("cnt_reset");
        reset = 1; bus.enable_decode = 1; bus.dout = 16'h1042; bus.npc_in = 16'h0000;
        for (int i = 0; i < 65535; i++) @(posedge clock);
        @(negedge clock);
        check("cnt_ffff", 64'(bus.instr_count), 64'h0000_0000_0000_FFFF);
        @(posedge clock);
        @(negedge clock);
        check("cnt_wrap", 64'(bus.instr_count), 64'h0);
        @(posedge clock);
        @(negedge clock);
        check("cnt_one", 64'(bus.instr_count), 64'h1);
        reset = 0;
        @(posedge clock);
        @(negedge clock);
        check("cnt_reset_en", 64'(bus.instr_count), 64'h0);
        check("cnt_reset_valid", 64'(bus.decode_valid), 64'h0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
